// File: rtl/sparse_kernel_decoder_pkg.sv
// Shared definitions for the sparse kernel decoder.
//   state_t        : controller states (IDLE, LOAD, READY)
//   clog2          : ceiling log2, minimum 1, for sizing pointers
//   popcount       : number of set bits in a mask of up to 64 bits
//   bit_row/bit_col: kernel slot -> (row, col) for constant lookup tables
//   row_mask       : all slots belonging to one kernel row
//   after_in_row   : slots to the right of a given slot in the same row
package sparse_kernel_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    localparam int MAX_BITS = 64;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return (result == 0) ? 1 : result;
    endfunction

    function automatic int popcount(input logic [MAX_BITS-1:0] mask);
        int count;
        count = 0;
        for (int i = 0; i < MAX_BITS; i++) begin
            if (mask[i]) count = count + 1;
        end
        return count;
    endfunction

    function automatic int bit_row(input int bit_idx, input int k);
        return bit_idx / k;
    endfunction

    function automatic int bit_col(input int bit_idx, input int k);
        return bit_idx % k;
    endfunction

    function automatic logic [MAX_BITS-1:0] row_mask(input int row, input int k);
        logic [MAX_BITS-1:0] mask;
        mask = '0;
        for (int j = 0; j < MAX_BITS; j++) begin
            if (j < k * k && (j / k) == row) mask[j] = 1'b1;
        end
        return mask;
    endfunction

    function automatic logic [MAX_BITS-1:0] after_in_row(input int bit_idx, input int k);
        logic [MAX_BITS-1:0] mask;
        mask = '0;
        for (int j = 0; j < MAX_BITS; j++) begin
            if (j > bit_idx && j < k * k && (j / k) == (bit_idx / k)) mask[j] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/sparse_kernel_decoder_next_set_bit.sv
// Combinational next-set-bit finder.
//   mask  : N-bit significance mask
//   start : first index allowed (may equal N, meaning "past the end")
//   idx   : lowest set index >= start (0 when none)
//   found : a set index >= start exists
module sparse_kernel_decoder_next_set_bit
    import sparse_kernel_decoder_pkg::*;
#(
    parameter int N  = 9,
    parameter int PW = 4
) (
    input  logic [N-1:0]  mask,
    input  logic [PW-1:0] start,
    output logic [PW-1:0] idx,
    output logic          found
);

    // Scan from the top down so the last hit is the lowest qualifying index.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(start))) begin
                idx   = PW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sparse_kernel_decoder.sv
// Sparse kernel decoder: weight front-end for the PE array.
// Accepts a KxK kernel as bitmap + compressed nonzero weights (sparse) or as
// K*K raw weights (dense), rebuilds it in parallel_out and replays nonzero
// (row, col, weight) triples on demand until the kernel is released.
//   clk, reset (async, active-low)
//   flag_valid/flag_ready/flag_data/mode : bitmap handshake, mode 1 = sparse
//   wei_valid/wei_ready/wei_data         : weight stream, row-major set bits
//   kernel_ready, kernel_nnz, parallel_out : rebuilt kernel
//   out_req -> out_valid, out_weight, out_row, out_col,
//              row_nnz, row_last, kernel_last : triple replay, 1-cycle latency
//   kernel_release : consumer done, discard kernel ("release" is a reserved
//                    word in SystemVerilog, hence the longer name)
module sparse_kernel_decoder
    import sparse_kernel_decoder_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int K          = 3,
    parameter int IDX_WIDTH  = 2,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic                      flag_valid,
    output logic                      flag_ready,
    input  logic [K*K-1:0]            flag_data,
    input  logic                      wei_valid,
    output logic                      wei_ready,
    input  logic [DATA_WIDTH-1:0]     wei_data,
    output logic                      kernel_ready,
    output logic [CNT_WIDTH-1:0]      kernel_nnz,
    output logic [DATA_WIDTH*K*K-1:0] parallel_out,
    input  logic                      out_req,
    output logic                      out_valid,
    output logic [DATA_WIDTH-1:0]     out_weight,
    output logic [IDX_WIDTH-1:0]      out_row,
    output logic [IDX_WIDTH-1:0]      out_col,
    output logic [CNT_WIDTH-1:0]      row_nnz,
    output logic                      row_last,
    output logic                      kernel_last,
    input  logic                      kernel_release
);

    localparam int N  = K * K;
    localparam int PW = clog2(N + 1);   // pointer may sit one past the last slot
    localparam int SW = clog2(N);       // slot address width
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [PW-1:0]        PTR_ONE = PW'(1);

    state_t state, state_next;

    logic [N-1:0]            bitmap;
    logic [DATA_WIDTH-1:0]   slots [N];
    logic [PW-1:0]           load_ptr, emit_ptr;
    logic [PW-1:0]           load_idx, emit_idx;
    logic                    load_found, emit_found;
    logic [CNT_WIDTH-1:0]    load_cnt, emit_cnt;

    // Constant slot -> row/col tables and row masks; no runtime divider.
    logic [IDX_WIDTH-1:0]    row_lut   [N];
    logic [IDX_WIDTH-1:0]    col_lut   [N];
    logic [N-1:0]            after_lut [N];
    logic [N-1:0]            row_masks [K];

    for (genvar i = 0; i < N; i++) begin : g_slot
        localparam int              ROW_I   = bit_row(i, K);
        localparam int              COL_I   = bit_col(i, K);
        localparam logic [63:0]     AFTER_I = after_in_row(i, K);
        assign row_lut[i]   = IDX_WIDTH'(ROW_I);
        assign col_lut[i]   = IDX_WIDTH'(COL_I);
        assign after_lut[i] = AFTER_I[N-1:0];
        assign parallel_out[i*DATA_WIDTH +: DATA_WIDTH] = slots[i];
    end

    for (genvar r = 0; r < K; r++) begin : g_row
        localparam logic [63:0] ROW_M = row_mask(r, K);
        assign row_masks[r] = ROW_M[N-1:0];
    end

    sparse_kernel_decoder_next_set_bit #(.N(N), .PW(PW)) u_load_finder (
        .mask  (bitmap),
        .start (load_ptr),
        .idx   (load_idx),
        .found (load_found)
    );

    sparse_kernel_decoder_next_set_bit #(.N(N), .PW(PW)) u_emit_finder (
        .mask  (bitmap),
        .start (emit_ptr),
        .idx   (emit_idx),
        .found (emit_found)
    );

    // Dense mode treats every slot as significant.
    logic [N-1:0]         flag_mask;
    logic [CNT_WIDTH-1:0] flag_nnz;
    assign flag_mask = mode ? flag_data : {N{1'b1}};
    assign flag_nnz  = CNT_WIDTH'(popcount(64'(flag_mask)));

    logic flag_fire, wei_fire, rel_fire, req_fire, load_done;
    assign flag_fire = flag_valid && (state == ST_IDLE);
    assign wei_fire  = wei_valid && (state == ST_LOAD);
    assign rel_fire  = kernel_release && (state == ST_READY);
    // Release wins over a simultaneous request; an empty kernel never emits.
    assign req_fire  = out_req && (state == ST_READY) && !kernel_release && emit_found;
    assign load_done = wei_fire && ((load_cnt + CNT_ONE) == kernel_nnz);

    logic [IDX_WIDTH-1:0] emit_row;
    logic [CNT_WIDTH-1:0] emit_row_nnz;
    logic                 emit_row_last, emit_kernel_last;
    assign emit_row         = row_lut[emit_idx[SW-1:0]];
    assign emit_row_nnz     = CNT_WIDTH'(popcount(64'(bitmap & row_masks[emit_row])));
    assign emit_row_last    = ~|(bitmap & after_lut[emit_idx[SW-1:0]]);
    assign emit_kernel_last = (emit_cnt + CNT_ONE) == kernel_nnz;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next   = state;
        flag_ready   = 1'b0;
        wei_ready    = 1'b0;
        kernel_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                flag_ready = 1'b1;
                if (flag_valid) state_next = (flag_nnz == '0) ? ST_READY : ST_LOAD;
            end
            ST_LOAD: begin
                wei_ready = 1'b1;
                if (load_done) state_next = ST_READY;
            end
            ST_READY: begin
                kernel_ready = 1'b1;
                if (kernel_release) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bitmap      <= '0;
            kernel_nnz  <= '0;
            load_ptr    <= '0;
            load_cnt    <= '0;
            emit_ptr    <= '0;
            emit_cnt    <= '0;
            out_valid   <= 1'b0;
            out_weight  <= '0;
            out_row     <= '0;
            out_col     <= '0;
            row_nnz     <= '0;
            row_last    <= 1'b0;
            kernel_last <= 1'b0;
            for (int i = 0; i < N; i++) slots[i] <= '0;
        end else begin
            out_valid <= 1'b0;

            if (flag_fire) begin
                bitmap     <= flag_mask;
                kernel_nnz <= flag_nnz;
                load_ptr   <= '0;
                load_cnt   <= '0;
                emit_ptr   <= '0;
                emit_cnt   <= '0;
                for (int i = 0; i < N; i++) slots[i] <= '0;
            end

            if (wei_fire && load_found) begin
                slots[load_idx[SW-1:0]] <= wei_data;
                load_ptr                <= load_idx + PTR_ONE;
                load_cnt                <= load_cnt + CNT_ONE;
            end

            if (rel_fire) begin
                bitmap     <= '0;
                kernel_nnz <= '0;
                load_ptr   <= '0;
                load_cnt   <= '0;
                emit_ptr   <= '0;
                emit_cnt   <= '0;
                for (int i = 0; i < N; i++) slots[i] <= '0;
            end

            if (req_fire) begin
                out_valid   <= 1'b1;
                out_weight  <= slots[emit_idx[SW-1:0]];
                out_row     <= emit_row;
                out_col     <= col_lut[emit_idx[SW-1:0]];
                row_nnz     <= emit_row_nnz;
                row_last    <= emit_row_last;
                kernel_last <= emit_kernel_last;
                // Wrap to the first set bit so the kernel can be replayed.
                if (emit_kernel_last) begin
                    emit_ptr <= '0;
                    emit_cnt <= '0;
                end else begin
                    emit_ptr <= emit_idx + PTR_ONE;
                    emit_cnt <= emit_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_sparse_kernel_decoder.sv
module tb_sparse_kernel_decoder;

    localparam int DW = 8;
    localparam int K  = 3;
    localparam int IW = 2;
    localparam int CW = 4;
    localparam int N  = K * K;

    logic            clk = 1'b0;
    logic            reset;
    logic            mode;
    logic            flag_valid;
    logic            flag_ready;
    logic [N-1:0]    flag_data;
    logic            wei_valid;
    logic            wei_ready;
    logic [DW-1:0]   wei_data;
    logic            kernel_ready;
    logic [CW-1:0]   kernel_nnz;
    logic [DW*N-1:0] parallel_out;
    logic            out_req;
    logic            out_valid;
    logic [DW-1:0]   out_weight;
    logic [IW-1:0]   out_row;
    logic [IW-1:0]   out_col;
    logic [CW-1:0]   row_nnz;
    logic            row_last;
    logic            kernel_last;
    logic            kernel_release;

    sparse_kernel_decoder #(
        .DATA_WIDTH(DW), .K(K), .IDX_WIDTH(IW), .CNT_WIDTH(CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mode          (mode),
        .flag_valid    (flag_valid),
        .flag_ready    (flag_ready),
        .flag_data     (flag_data),
        .wei_valid     (wei_valid),
        .wei_ready     (wei_ready),
        .wei_data      (wei_data),
        .kernel_ready  (kernel_ready),
        .kernel_nnz    (kernel_nnz),
        .parallel_out  (parallel_out),
        .out_req       (out_req),
        .out_valid     (out_valid),
        .out_weight    (out_weight),
        .out_row       (out_row),
        .out_col       (out_col),
        .row_nnz       (row_nnz),
        .row_last      (row_last),
        .kernel_last   (kernel_last),
        .kernel_release(kernel_release)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] row;
        logic [IW-1:0] col;
        logic [DW-1:0] w;
        logic [CW-1:0] rnnz;
        logic          rl;
        logic          kl;
    } trip_t;

    int checks = 0;
    int errors = 0;

    trip_t        sb [$];
    trip_t        m_list [$];
    int           m_ptr;
    logic [N-1:0] m_bitmap;
    logic [DW-1:0] m_slots [N];
    int           m_fill;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW*N-1:0] exp_parallel();
        logic [DW*N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = m_slots[i];
        return v;
    endfunction

    // Expected replay order straight from the kernel definition.
    task automatic build_list();
        trip_t t;
        int    r;
        int    cnt;
        int    later_row;
        int    later_any;
        m_list.delete();
        m_ptr = 0;
        for (int b = 0; b < N; b++) begin
            if (m_bitmap[b]) begin
                r = b / K;
                cnt = 0;
                for (int c = 0; c < K; c++) if (m_bitmap[r*K + c]) cnt++;
                later_row = 0;
                later_any = 0;
                for (int j = b + 1; j < N; j++) begin
                    if (m_bitmap[j]) begin
                        later_any = 1;
                        if (j / K == r) later_row = 1;
                    end
                end
                t.row  = IW'(r);
                t.col  = IW'(b % K);
                t.w    = m_slots[b];
                t.rnnz = CW'(cnt);
                t.rl   = (later_row == 0);
                t.kl   = (later_any == 0);
                m_list.push_back(t);
            end
        end
    endtask

    always @(negedge clk) begin
        trip_t e;
        if (reset && out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check("triple", {out_row, out_col, out_weight, row_nnz, row_last, kernel_last}, e);
            end
        end
    end

    task automatic send_flag(input logic m, input logic [N-1:0] f);
        int budget;
        budget = 20;
        mode = m;
        flag_data = f;
        flag_valid = 1'b1;
        while (!flag_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) check("flag_timeout", 0, 1);
        tick();
        flag_valid = 1'b0;
        flag_data = N'($urandom);
        m_bitmap = m ? f : {N{1'b1}};
        for (int i = 0; i < N; i++) m_slots[i] = '0;
        m_fill = 0;
    endtask

    task automatic send_wei(input logic [DW-1:0] w, input bit stall);
        int budget;
        int seen;
        if (stall) begin
            wei_valid = 1'b0;
            wei_data = 8'hEE;
            tick();
        end
        wei_valid = 1'b1;
        wei_data = w;
        budget = 20;
        while (!wei_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) check("wei_timeout", 0, 1);
        tick();
        wei_valid = 1'b0;
        wei_data = 8'hEE;
        seen = 0;
        for (int b = 0; b < N; b++) begin
            if (m_bitmap[b]) begin
                if (seen == m_fill) m_slots[b] = w;
                seen++;
            end
        end
        m_fill++;
    endtask

    task automatic load_kernel(input logic m, input logic [N-1:0] f,
                               input logic [DW-1:0] ws [$], input bit stall);
        int budget;
        send_flag(m, f);
        foreach (ws[i]) send_wei(ws[i], stall);
        budget = 10;
        while (!kernel_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) check("kernel_ready_timeout", 0, 1);
        build_list();
    endtask

    task automatic request(input int n);
        for (int i = 0; i < n; i++) begin
            out_req = 1'b1;
            if (m_list.size() > 0) begin
                sb.push_back(m_list[m_ptr]);
                m_ptr = (m_ptr + 1) % m_list.size();
            end
            tick();
        end
        out_req = 1'b0;
        tick();
        tick();
        check("sb_drain", 128'(sb.size()), 0);
    endtask

    task automatic release_kernel();
        kernel_release = 1'b1;
        tick();
        kernel_release = 1'b0;
        check("rel_flag_ready", flag_ready, 1);
        check("rel_kernel_ready", kernel_ready, 0);
        check("rel_parallel", parallel_out, 0);
        check("rel_nnz", kernel_nnz, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_flag_ready"}, flag_ready, 1);
        check({tag, "_wei_ready"}, wei_ready, 0);
        check({tag, "_kernel_ready"}, kernel_ready, 0);
        check({tag, "_nnz"}, kernel_nnz, 0);
        check({tag, "_parallel"}, parallel_out, 0);
        check({tag, "_outs"}, {out_valid, out_weight, out_row, out_col, row_nnz, row_last, kernel_last}, 0);
    endtask

    logic [DW-1:0] ws [$];

    initial begin
        reset = 1'b0;
        mode = 1'b1;
        flag_valid = 1'b0;
        flag_data = '0;
        wei_valid = 1'b0;
        wei_data = '0;
        out_req = 1'b0;
        kernel_release = 1'b0;
        #12;
        check_reset_values("rst");
        reset = 1'b1;
        tick();
        check_reset_values("idle");

        // Sparse load with an empty middle row, then a re-traversal.
        ws = '{8'h11, 8'h22, 8'h33, 8'h44};
        load_kernel(1'b1, 9'h143, ws, 1'b0);
        check("sp_nnz", kernel_nnz, 4);
        check("sp_wei_ready", wei_ready, 0);
        check("sp_parallel", parallel_out, exp_parallel());
        check("sp_parallel_const", parallel_out, 72'h44_00_33_00_00_00_00_22_11);
        request(4);
        request(1);
        release_kernel();

        // Dense load: flag_data must be ignored.
        ws = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        load_kernel(1'b0, 9'h0AA, ws, 1'b0);
        check("dn_nnz", kernel_nnz, 9);
        check("dn_parallel", parallel_out, exp_parallel());
        request(9);
        release_kernel();

        // Empty kernel goes straight to READY and never emits.
        send_flag(1'b1, '0);
        build_list();
        check("em_kernel_ready", kernel_ready, 1);
        check("em_nnz", kernel_nnz, 0);
        for (int i = 0; i < 3; i++) begin
            check("em_wei_ready", wei_ready, 0);
            tick();
        end
        request(2);
        release_kernel();

        // Stalled weight stream: only handshaked beats land.
        ws = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        load_kernel(1'b1, 9'h143, ws, 1'b1);
        check("st_parallel", parallel_out, exp_parallel());
        request(2);
        // Release beats a simultaneous request.
        kernel_release = 1'b1;
        out_req = 1'b1;
        tick();
        kernel_release = 1'b0;
        out_req = 1'b0;
        check("pr_flag_ready", flag_ready, 1);
        check("pr_kernel_ready", kernel_ready, 0);
        tick();
        check("pr_sb_empty", 128'(sb.size()), 0);

        // Reset mid-load aborts the kernel; a fresh load then works.
        send_flag(1'b1, 9'h143);
        send_wei(8'h11, 1'b0);
        send_wei(8'h22, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("mid");
        tick();
        reset = 1'b1;
        tick();
        check_reset_values("post");
        ws = '{8'h55, 8'h66, 8'h77, 8'h88};
        load_kernel(1'b1, 9'h143, ws, 1'b0);
        check("rs_nnz", kernel_nnz, 4);
        check("rs_parallel", parallel_out, exp_parallel());
        request(4);
        release_kernel();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
